// File: rtl/seg_disp_arbiter_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the FSM state encoding, source count, word width and round-robin helpers.
package seg_disp_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int NUM_SRC = 3;
    localparam int IDX_W   = 2;
    localparam int DIS_W   = 24;

    localparam logic [DIS_W-1:0] IDLE_DATA_DEF = 24'h000000;

    // Search last+1, last+2, last (mod NUM_SRC); returns last when nothing requests.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(last) + i) % NUM_SRC;
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [NUM_SRC-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_SRC-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/seg_disp_arbiter_tick_gen.sv
// Hold-time prescaler: counts 0..TICK_DIV-1 while enabled, one-cycle tick on wrap.
// Clear forces the count back to zero so every grant starts a fresh tick period.
module disp_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign o_tick = i_en && w_wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the 6-digit display with a minimum hold before preemption.
// One GAP cycle of IDLE_DATA separates consecutive owners to avoid ghosting.
module seg_disp_arbiter
    import seg_disp_arbiter_pkg::*;
#(
    parameter int               TICK_DIV   = 50_000_000,
    parameter int               HOLD_TICKS = 3,
    parameter logic [DIS_W-1:0] IDLE_DATA  = IDLE_DATA_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic [DIS_W-1:0]   req_data0,
    input  logic [DIS_W-1:0]   req_data1,
    input  logic [DIS_W-1:0]   req_data2,
    output logic [NUM_SRC-1:0] grant,
    output logic [DIS_W-1:0]   dis_data,
    output logic               busy
);

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_gidx;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [NUM_SRC-1:0] r_grant;
    logic [DIS_W-1:0]   r_dis_data;
    logic               r_busy;

    logic [DIS_W-1:0]   w_data [NUM_SRC];
    logic [IDX_W-1:0]   w_win;
    logic               w_any_req;
    logic               w_own_req;
    logic               w_other_req;
    logic               w_tick;
    logic               w_clr;
    logic               w_hold_done;

    assign w_data[0]   = req_data0;
    assign w_data[1]   = req_data1;
    assign w_data[2]   = req_data2;
    assign w_win       = rr_pick(req, r_last);
    assign w_any_req   = |req;
    assign w_own_req   = req[r_gidx];
    assign w_other_req = |(req & ~onehot(r_gidx));
    assign w_clr       = (r_state != ST_GRANT);

    // The exit decision is registered, so act on the final tick itself to keep
    // the on-screen hold at exactly HOLD_TICKS*TICK_DIV cycles.
    assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_TICKS)) ||
                         (w_tick && (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1)));

    disp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_clr),
        .i_en   (r_state == ST_GRANT),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= IDX_W'(NUM_SRC - 1);
            r_gidx     <= '0;
            r_hold_cnt <= '0;
            r_grant    <= '0;
            r_dis_data <= IDLE_DATA;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_GAP: begin
                    if (w_any_req) begin
                        r_state    <= ST_GRANT;
                        r_last     <= w_win;
                        r_gidx     <= w_win;
                        r_hold_cnt <= '0;
                        r_grant    <= onehot(w_win);
                        r_dis_data <= w_data[w_win];
                        r_busy     <= 1'b1;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_grant    <= '0;
                        r_dis_data <= IDLE_DATA;
                        r_busy     <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Voluntary release wins over everything, hold or not.
                    if (!w_own_req || (w_hold_done && w_other_req)) begin
                        r_state    <= ST_GAP;
                        r_grant    <= '0;
                        r_dis_data <= IDLE_DATA;
                        r_busy     <= 1'b0;
                    end else begin
                        r_dis_data <= w_data[r_gidx];
                        if (w_tick && (r_hold_cnt != HOLD_W'(HOLD_TICKS))) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_grant    <= '0;
                    r_dis_data <= IDLE_DATA;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign dis_data = r_dis_data;
    assign busy     = r_busy;

endmodule
